ad796x_dac_spi_stream: RTL
==========================

// Module: ad796x_dac_spi_stream
// PURPOSE
//  Parametrised streaming sequencer: pops AD796x samples from the ADC FIFO, scales them to DAC width and
//  drives the Wishbone-style SPI master register port (adr/cmd_word/cmd_stb) to ship one DAC word per sample.
//  Adds over the previous generation: generic widths/divider/slave-select, run enable, timeout recovery,
//  transfer counter. Sits between the ADC FIFO read side and the SPI master core; all logic on posedge clk.
// PARAMETERS
//  ADC_W       16       ADC sample width
//  DAC_W       14       DAC code width (DAC_W <= ADC_W)
//  CMD_BITS    2'b00    DAC command bits prefixed above the code
//  CHAR_LEN    16       SPI character length written to CTRL[6:0] (= DAC_W + 2)
//  DIVIDER     0        value written to DIVIDE register (0x14)
//  SS_MASK     8'h01    value written to SS register (0x18)
//  TIMEOUT_CYC 4096     max cycles waiting for int_o; 0 disables timeout
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous active-high reset
//  en           in   1        run enable; low = stop popping after current transfer
//  empty        in   1        ADC FIFO empty flag
//  adc_dat_i    in   ADC_W    ADC FIFO read data, valid cycle after rd_en
//  int_o        in   1        SPI master transfer-done interrupt (level)
//  rd_en        out  1        ADC FIFO pop, one-cycle pulse
//  adr          out  8        SPI master register address
//  cmd_word     out  34       [32]=write flag, [31:0]=register data
//  cmd_stb      out  1        register write strobe
//  busy         out  1        high outside WAIT_DATA
//  xfer_cnt     out  16       completed transfers, wraps 0xFFFF->0
//  timeout_err  out  1        sticky; set on int_o timeout
//  offset_i     in   ADC_W    signed offset (only with AD796X_OFFSET_EN)
// BEHAVIOUR
//  Reset (any cycle, incl. mid-transfer): state=INIT_DIV; rd_en,cmd_stb,busy,timeout_err=0; adr=0,
//   cmd_word=0, xfer_cnt=0, phase=0. All outputs registered.
//  Register write = 3 cycles: phase0 adr/cmd_word valid, cmd_stb=0; phase1,2 same with cmd_stb=1; then next state.
//  States:
//   INIT_DIV  write 0x14 <= {1'b1,DIVIDER[31:0]}
//   INIT_CTRL write 0x10 <= {1'b1,32'h3000|CHAR_LEN[6:0]}   (ASS=1, IE=1, GO=0)
//   INIT_SS   write 0x18 <= {1'b1,24'h0,SS_MASK}            -> WAIT_DATA
//   WAIT_DATA en && !empty -> POP; else hold (busy=0)
//   POP       rd_en=1 for exactly one cycle -> CAPTURE
//   CAPTURE   register dac_code from adc_dat_i -> WR_TX
//   WR_TX     write 0x00 <= {1'b1,zero-pad,CMD_BITS,dac_code}
//   WR_GO     write 0x10 <= {1'b1,32'h3100|CHAR_LEN[6:0]}  -> WAIT_INT, timer=0
//   WAIT_INT  int_o=1 -> xfer_cnt+1, WAIT_DATA; timer==TIMEOUT_CYC-1 (TIMEOUT_CYC!=0) -> timeout_err=1, INIT_DIV
//  int_o sampled only in WAIT_INT; ignored elsewhere. empty sampled only in WAIT_DATA.
//  en deassert mid-transfer: transfer completes normally; no further pop.
//  Never pops when empty=1; at most one pop per transfer; no pop before INIT_SS done.
//  Conversion (default): dac_code = adc_dat_i[ADC_W-1 -: DAC_W] (truncate LSBs, no rounding).
//  Min loop latency pop->GO strobe end: 1+1+3+3 = 8 cycles.
// CONFIGURATION
//  AD796X_OFFSET_EN defined: offset_i port exists; CAPTURE computes signed adc_dat_i+offset_i in ADC_W+1
//   bits, saturates to [-2^(ADC_W-1), 2^(ADC_W-1)-1], then truncates to DAC_W. Adds no cycles.
//  Undefined: no offset_i port; pure truncation as above.
// TESTING
//  T1 rst 1 cycle, empty=1: three INIT writes (0x14:1_00000000, 0x10:1_00003010, 0x18:1_00000001), each
//     stb=0,1,1; then idle, rd_en never asserted, busy=0.
//  T2 FIFO holds 0xABCD, int_o 20 cycles after GO: one rd_en pulse; 0x00 write 1_00002AF3; 0x10 write
//     1_00003110; xfer_cnt=1; back to WAIT_DATA.
//  T3 4 samples queued, int_o prompt: 4 pops, 4 TX writes in order, xfer_cnt=4; en dropped after 2nd GO ->
//     only 2 transfers, busy falls after 2nd int_o.
//  T4 TIMEOUT_CYC=8, int_o held 0: timeout_err=1 after 8 WAIT_INT cycles, INIT sequence replays, flag stays 1.
//  T5 rst asserted during WR_TX phase1: next cycle cmd_stb=0, cmd_word=0, state INIT_DIV; no extra pop.
//  T6 AD796X_OFFSET_EN, adc=0x7FF0, offset=0x0100: saturate 0x7FFF -> code 0x1FFF; adc=0x8010,
//     offset=0xFF00: saturate 0x8000 -> code 0x2000.

Source files
------------

// File: rtl/ad796x_dac_spi_stream.sv
// ad796x_dac_spi_stream
// Pops AD796x samples from the ADC FIFO, scales each one to DAC width and
// ships it to the SPI master core as a TX register write and a GO write.
// The SPI core is initialised after every reset and after every interrupt timeout.
//
// Optional feature: define AD796X_OFFSET_EN to add the offset_i port. The
// signed offset is then added with saturation before truncation to DAC width.
//
// state       | meaning
// ------------+--------------------------------------------------------
// INIT_DIV    | write clock divider register (0x14)
// INIT_CTRL   | write CTRL (0x10): char length, ASS=1, IE=1, GO=0
// INIT_SS     | write slave-select register (0x18)
// WAIT_DATA   | idle; pop when enabled and FIFO not empty (busy=0)
// POP         | one-cycle FIFO read strobe
// CAPTURE     | FIFO data valid; convert and latch DAC code
// WR_TX       | write TX register (0x00) with command bits + code
// WR_GO       | write CTRL (0x10) with GO set
// WAIT_INT    | wait for transfer-done interrupt or timeout
//
// A register write takes three cycles: phase 0 presents adr/cmd_word with
// cmd_stb low, and phases 1 and 2 hold the same values with cmd_stb high.
// All outputs are registered from the next state, so they line up with the
// state register. The one exception is the first cycle after reset, which
// still shows the cleared reset values.

module ad796x_dac_spi_stream #(
  parameter int          ADC_W       = 16,
  parameter int          DAC_W       = 14,
  parameter logic [1:0]  CMD_BITS    = 2'b00,
  parameter int          CHAR_LEN    = 16,
  parameter logic [31:0] DIVIDER     = 32'd0,
  parameter logic [7:0]  SS_MASK     = 8'h01,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             empty,
  input  logic [ADC_W-1:0] adc_dat_i,
`ifdef AD796X_OFFSET_EN
  input  logic [ADC_W-1:0] offset_i,
`endif
  input  logic             int_o,
  output logic             rd_en,
  output logic [7:0]       adr,
  output logic [33:0]      cmd_word,
  output logic             cmd_stb,
  output logic             busy,
  output logic [15:0]      xfer_cnt,
  output logic             timeout_err
);

  localparam logic [7:0]  ADR_TX    = 8'h00;
  localparam logic [7:0]  ADR_CTRL  = 8'h10;
  localparam logic [7:0]  ADR_DIV   = 8'h14;
  localparam logic [7:0]  ADR_SS    = 8'h18;
  localparam logic [6:0]  CHAR7     = 7'(CHAR_LEN);
  localparam logic [31:0] CTRL_IDLE = 32'h0000_3000 | {25'd0, CHAR7};
  localparam logic [31:0] CTRL_GO   = 32'h0000_3100 | {25'd0, CHAR7};

  // Interrupt timer counts down from TIMEOUT_CYC-1; expiry is the terminal count of zero.
  localparam int             TMR_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;
  localparam bit             TMR_ON   = (TIMEOUT_CYC != 0);

  typedef enum logic [3:0] {
    S_INIT_DIV,
    S_INIT_CTRL,
    S_INIT_SS,
    S_WAIT_DATA,
    S_POP,
    S_CAPTURE,
    S_WR_TX,
    S_WR_GO,
    S_WAIT_INT
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       phase, phase_nxt;
  logic [TMR_W-1:0] tmr;
  logic             tmr_expired;
  logic [DAC_W-1:0] dac_code;

  logic [ADC_W-1:0] conv_full;
  logic [DAC_W-1:0] conv_code;
  logic             unused_conv_bits;

  logic             d_rd_en;
  logic [7:0]       d_adr;
  logic [31:0]      d_data;
  logic [33:0]      d_word;
  logic             d_wr;
  logic             d_stb;
  logic             d_busy;
  logic [DAC_W-1:0] tx_code;

  assign tmr_expired = TMR_ON && (tmr == '0);

`ifdef AD796X_OFFSET_EN
  logic signed [ADC_W:0] off_sum;

  // Offset add in one extra bit; clamp to the ADC_W signed range on overflow.
  always_comb begin
    off_sum   = $signed({adc_dat_i[ADC_W-1], adc_dat_i}) + $signed({offset_i[ADC_W-1], offset_i});
    conv_full = off_sum[ADC_W-1:0];
    if (off_sum[ADC_W] != off_sum[ADC_W-1]) begin
      conv_full = off_sum[ADC_W] ? {1'b1, {(ADC_W-1){1'b0}}} : {1'b0, {(ADC_W-1){1'b1}}};
    end
  end
`else
  assign conv_full = adc_dat_i;
`endif

  // Keep the MSBs and drop the LSBs without rounding.
  assign conv_code        = conv_full[ADC_W-1 -: DAC_W];
  assign unused_conv_bits = ^conv_full;

  // State register: state and write phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT_DIV;
      phase <= 2'd0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Next-state logic; every write state steps through phases 0..2 before advancing.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      S_INIT_DIV, S_INIT_CTRL, S_INIT_SS, S_WR_TX, S_WR_GO: begin
        if (phase == 2'd2) begin
          phase_nxt = 2'd0;
          case (state)
            S_INIT_DIV:  state_nxt = S_INIT_CTRL;
            S_INIT_CTRL: state_nxt = S_INIT_SS;
            S_INIT_SS:   state_nxt = S_WAIT_DATA;
            S_WR_TX:     state_nxt = S_WR_GO;
            default:     state_nxt = S_WAIT_INT;
          endcase
        end else begin
          phase_nxt = phase + 2'd1;
        end
      end
      S_WAIT_DATA: begin
        if (en && !empty) state_nxt = S_POP;
      end
      S_POP:     state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_WR_TX;
      S_WAIT_INT: begin
        if (int_o)            state_nxt = S_WAIT_DATA;
        else if (tmr_expired) state_nxt = S_INIT_DIV;
      end
      default: begin
        state_nxt = S_INIT_DIV;
        phase_nxt = 2'd0;
      end
    endcase
  end

  // Output decode from the next state. While leaving CAPTURE the code is taken
  // straight from the converter, because dac_code is only latched on that same edge.
  always_comb begin
    d_rd_en = 1'b0;
    d_adr   = 8'h00;
    d_data  = 32'd0;
    d_wr    = 1'b0;
    d_busy  = (state_nxt != S_WAIT_DATA);
    tx_code = (state == S_CAPTURE) ? conv_code : dac_code;
    case (state_nxt)
      S_INIT_DIV: begin
        d_wr   = 1'b1;
        d_adr  = ADR_DIV;
        d_data = DIVIDER;
      end
      S_INIT_CTRL: begin
        d_wr   = 1'b1;
        d_adr  = ADR_CTRL;
        d_data = CTRL_IDLE;
      end
      S_INIT_SS: begin
        d_wr   = 1'b1;
        d_adr  = ADR_SS;
        d_data = {24'd0, SS_MASK};
      end
      S_POP: d_rd_en = 1'b1;
      S_WR_TX: begin
        d_wr                = 1'b1;
        d_adr               = ADR_TX;
        d_data[DAC_W-1:0]   = tx_code;
        d_data[DAC_W +: 2]  = CMD_BITS;
      end
      S_WR_GO: begin
        d_wr   = 1'b1;
        d_adr  = ADR_CTRL;
        d_data = CTRL_GO;
      end
      default: ;
    endcase
    d_stb  = d_wr && (phase_nxt != 2'd0);
    d_word = d_wr ? {1'b0, 1'b1, d_data} : 34'd0;
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en    <= 1'b0;
      adr      <= 8'h00;
      cmd_word <= 34'd0;
      cmd_stb  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_en    <= d_rd_en;
      adr      <= d_adr;
      cmd_word <= d_word;
      cmd_stb  <= d_stb;
      busy     <= d_busy;
    end
  end

  // Datapath: code latch, interrupt timer, transfer counter, sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_code    <= '0;
      tmr         <= TMR_LOAD;
      xfer_cnt    <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_CAPTURE) dac_code <= conv_code;
      if (state != S_WAIT_INT)  tmr <= TMR_LOAD;
      else if (!tmr_expired)    tmr <= tmr - 1'b1;
      if (state == S_WAIT_INT && int_o)                      xfer_cnt    <= xfer_cnt + 16'd1;
      if (state == S_WAIT_INT && !int_o && tmr_expired)      timeout_err <= 1'b1;
    end
  end

endmodule
